cplx_sign_pipe: RTL and testbench

Parametrised, pipelined complex sign-manipulation unit for IEEE-754 complex samples packed as {real, imag}. It performs pass-through, conjugate, negate or multiply-by-j per sample, using sign-bit flips and lane swaps instead of an adder. A valid bit and per-sample mode travel with the data through a stallable pipeline of configurable depth. It sits in the complex datapath wherever a conjugated or rotated operand has to line up with other fixed-latency units such as the adder/subtractor and multiplier.

---
 rtl/cplx_sign_pipe.sv | 137 +++++++++++++
 tb/tb_cplx_sign_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cplx_sign_pipe.sv
// cplx_sign_pipe
// Pipelined complex sign-manipulation unit for IEEE-754 complex samples
// packed as {real, imag}. Supports pass, conjugate, negate and multiply-by-j
// using only sign-bit flips and lane swaps, so exponent/mantissa bits
// (including NaN payloads) travel bit-exact.
//
// Stage 1 registers the transformed sample; stages 2..LATENCY are plain
// delay registers. All stages freeze while stall is high. Reset is
// synchronous, active high, wins over stall and flushes samples in flight.
//
// Optional build macro:
//   CPLX_SIGN_ZERO_POS_EN - when defined, a +/-0 component that the selected
//   mode negates comes out as +0 (0 - x semantics). When undefined, zero
//   components are sign-flipped like any other value.
//
// LATENCY must lie in 1..16.

module cplx_sign_pipe #(
    parameter int W       = 32,
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2*W-1:0] A,
    input  logic [1:0]     mode,
    input  logic           stall,
    output logic [2*W-1:0] result,
    output logic           out_valid
);

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_CONJ = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_MULJ = 2'b11;

    // Negate one IEEE-754 component by touching only its sign bit.
    // In the zero-positive build, a magnitude of zero always yields +0.
    function automatic logic [W-1:0] flip_sign(input logic [W-1:0] x);
        logic [W-1:0] r;
`ifdef CPLX_SIGN_ZERO_POS_EN
        if (x[W-2:0] == {(W-1){1'b0}}) begin
            r = {W{1'b0}};
        end else begin
            r = {~x[W-1], x[W-2:0]};
        end
`else
        r = {~x[W-1], x[W-2:0]};
`endif
        return r;
    endfunction

    logic [W-1:0] in_re_s;
    logic [W-1:0] in_im_s;
    logic [W-1:0] xf_re_s;
    logic [W-1:0] xf_im_s;

    assign in_re_s = A[2*W-1:W];
    assign in_im_s = A[W-1:0];

    // Per-sample transform selected by mode; applied whether or not
    // the slot is valid, since bubbles carry don't-care data anyway.
    always_comb begin
        xf_re_s = in_re_s;
        xf_im_s = in_im_s;
        case (mode)
            MODE_PASS: begin
                xf_re_s = in_re_s;
                xf_im_s = in_im_s;
            end
            MODE_CONJ: begin
                xf_re_s = in_re_s;
                xf_im_s = flip_sign(in_im_s);
            end
            MODE_NEG: begin
                xf_re_s = flip_sign(in_re_s);
                xf_im_s = flip_sign(in_im_s);
            end
            MODE_MULJ: begin
                // j*(re + j*im) = -im + j*re
                xf_re_s = flip_sign(in_im_s);
                xf_im_s = in_re_s;
            end
            default: begin
                xf_re_s = in_re_s;
                xf_im_s = in_im_s;
            end
        endcase
    end

    logic [2*W-1:0]     data_q [LATENCY];
    logic [2*W-1:0]     data_d [LATENCY];
    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] valid_d;

    // Next-state of the pipeline: hold on stall, otherwise shift one stage
    // with the freshly transformed sample entering stage 1.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            data_d[i] = data_q[i];
        end
        valid_d = valid_q;
        if (stall) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_d[i] = data_q[i];
            end
            valid_d = valid_q;
        end else begin
            data_d[0]  = {xf_re_s, xf_im_s};
            valid_d[0] = in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
    end

    // Stage registers; reset clears data and valid and discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= {(2*W){1'b0}};
            end
            valid_q <= {LATENCY{1'b0}};
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
        end
    end

    // The last stage register drives the outputs directly.
    assign result    = data_q[LATENCY-1];
    assign out_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_cplx_sign_pipe.sv
// Self-checking bench for cplx_sign_pipe.
// DUT1: W=32, LATENCY=4 with a per-cycle reference model comparison plus
// directed literal checks. DUT2: W=64, LATENCY=1 with directed literals.

module tb_cplx_sign_pipe;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [63:0]  A = 64'd0;
    logic [1:0]   mode = 2'b00;
    logic         stall = 1'b0;
    logic [63:0]  result;
    logic         out_valid;

    logic         rst2 = 1'b1;
    logic         in_valid2 = 1'b0;
    logic [127:0] A2 = 128'd0;
    logic [1:0]   mode2 = 2'b00;
    logic         stall2 = 1'b0;
    logic [127:0] result2;
    logic         out_valid2;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    cplx_sign_pipe #(.W(32), .LATENCY(LAT)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .mode(mode),
        .stall(stall), .result(result), .out_valid(out_valid)
    );

    cplx_sign_pipe #(.W(64), .LATENCY(1)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .A(A2), .mode(mode2),
        .stall(stall2), .result(result2), .out_valid(out_valid2)
    );

    // Arithmetic meaning of negating a float: flip its sign (optionally zero -> +0).
    function automatic logic [31:0] fneg(input logic [31:0] x);
`ifdef CPLX_SIGN_ZERO_POS_EN
        if ((x & 32'h7FFFFFFF) == 32'd0) return 32'd0;
`endif
        return x ^ 32'h80000000;
    endfunction

    // Complex operation on (re, im): identity, conj, -z, j*z.
    function automatic logic [63:0] cop(input logic [63:0] z, input logic [1:0] m);
        logic [31:0] re;
        logic [31:0] im;
        re = z[63:32];
        im = z[31:0];
        if (m == 2'd0) return {re, im};
        if (m == 2'd1) return {re, fneg(im)};
        if (m == 2'd2) return {fneg(re), fneg(im)};
        return {fneg(im), re};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: history of accepted slots; output is the slot accepted
    // LAT advancing edges ago, zero/invalid if fewer since reset.
    logic [64:0] hist[$];
    logic [64:0] e_s;

    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
        end else if (!stall) begin
            hist.push_back({in_valid, cop(A, mode)});
            if (hist.size() > LAT) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (hist.size() < LAT) e_s = 65'd0;
            else e_s = hist[0];
            check("model_valid", {127'd0, out_valid}, {127'd0, e_s[64]});
            if (e_s[64] || hist.size() < LAT)
                check("model_result", {64'd0, result}, {64'd0, e_s[63:0]});
        end
    end

    logic [63:0] exp2 [4];
    logic [63:0] sa [8];
    int          exp_idx [16];

    initial begin
        exp2[0] = 64'h3F800000_40000000;
        exp2[1] = 64'h3F800000_C0000000;
        exp2[2] = 64'hBF800000_C0000000;
        exp2[3] = 64'hC0000000_3F800000;
        exp_idx = '{-1, -1, -1, -1, 0, 1, 1, 1, 1, 2, 3, 4, 5, 6, 7, -1};
        for (int i = 0; i < 8; i++)
            sa[i] = {32'h3F800000 + 32'(i) * 32'h00100000, 32'h40400000 ^ 32'(i)};

        // Reset
        repeat (3) @(negedge clk);
        check("reset_result", {64'd0, result}, 128'd0);
        check("reset_valid", {127'd0, out_valid}, 128'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single conjugate sample, latency 4
        @(negedge clk);
        A = 64'h3F800000_40000000; mode = 2'b01; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            check("lat_valid", {127'd0, out_valid}, {127'd0, (i == 3)});
            if (i == 3) check("lat_result", {64'd0, result}, {64'd0, 64'h3F800000_C0000000});
        end

        // Four back-to-back modes
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                check("modes_valid", {127'd0, out_valid}, 128'd1);
                check("modes_result", {64'd0, result}, {64'd0, exp2[c-4]});
            end
            A = 64'h3F800000_40000000;
            mode = 2'(c);
            in_valid = (c < 4);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Stream of 8 with a 3-cycle stall; source holds while stalled
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                if (exp_idx[c] < 0) begin
                    check("stall_valid", {127'd0, out_valid}, 128'd0);
                end else begin
                    check("stall_valid", {127'd0, out_valid}, 128'd1);
                    check("stall_result", {64'd0, result},
                          {64'd0, cop(sa[exp_idx[c]], 2'(exp_idx[c] % 4))});
                end
                stall = (c >= 5 && c <= 7);
                in_valid = (idx < 8);
                if (idx < 8) begin
                    A = sa[idx];
                    mode = 2'(idx % 4);
                end
                if (!stall && idx < 8) idx++;
            end
        end
        stall = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset with stall while 3 samples are in flight
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            A = 64'h40A00000_C1200000 + 64'(c);
            mode = 2'b10;
            in_valid = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1; stall = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_flush_result", {64'd0, result}, 128'd0);
        check("rst_flush_valid", {127'd0, out_valid}, 128'd0);
        rst = 1'b0; stall = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst_no_ghost", {127'd0, out_valid}, 128'd0);
        end

        // Signed zeros negated
        @(negedge clk);
        A = 64'h00000000_80000000; mode = 2'b10; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
`ifdef CPLX_SIGN_ZERO_POS_EN
        check("zero_neg", {64'd0, result}, {64'd0, 64'h00000000_00000000});
`else
        check("zero_neg", {64'd0, result}, {64'd0, 64'h80000000_00000000});
`endif
        check("zero_neg_valid", {127'd0, out_valid}, 128'd1);
        repeat (4) @(negedge clk);

        // DUT2: W=64, LATENCY=1
        check("d2_reset_result", result2, 128'd0);
        check("d2_reset_valid", {127'd0, out_valid2}, 128'd0);
        rst2 = 1'b0;
        A2 = 128'h7FF8000000000001_3FF0000000000000; mode2 = 2'b11; in_valid2 = 1'b1;
        @(negedge clk);
        check("d2_mulj", result2, 128'hBFF0000000000000_7FF8000000000001);
        check("d2_mulj_valid", {127'd0, out_valid2}, 128'd1);
        stall2 = 1'b1;
        A2 = 128'h0000000000000001_0000000000000002; mode2 = 2'b00;
        @(negedge clk);
        check("d2_stall_hold", result2, 128'hBFF0000000000000_7FF8000000000001);
        check("d2_stall_valid", {127'd0, out_valid2}, 128'd1);
        stall2 = 1'b0; in_valid2 = 1'b0;
        @(negedge clk);
        check("d2_bubble", {127'd0, out_valid2}, 128'd0);
        A2 = 128'h3FF0000000000000_4000000000000000; mode2 = 2'b01; in_valid2 = 1'b1;
        @(negedge clk);
        check("d2_conj", result2, 128'h3FF0000000000000_C000000000000000);
        check("d2_conj_valid", {127'd0, out_valid2}, 128'd1);
        in_valid2 = 1'b0;
        @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
